// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and sizing helpers for the memory arbiter.
package mem_arb_pkg;
  typedef enum logic {IDLE, BUSY} arb_state_t;
  typedef enum logic {OWN_IF, OWN_D} arb_owner_t;
  localparam int BYTE_W = 8;
  function automatic int be_width(input int data_w);
    return data_w / BYTE_W;
  endfunction
endpackage

// File: rtl/mem_arb_lat_timer.sv
// mem_arb_lat_timer: counts 1..MEM_LAT after load, done at MEM_LAT; load on done restarts (ports: clk, rst_n, load, done).
module mem_arb_lat_timer #(
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic done
);
  localparam int CW = $clog2(MEM_LAT + 1);
  logic [CW-1:0] cnt;
  assign done = cnt == CW'(MEM_LAT);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= CW'(1);
    else if (done) cnt <= '0;
    else if (cnt != '0) cnt <= cnt + 1'b1;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory arbiter for IF/D requesters (ports: if_*, d_*, mem_*, stall_f/m, perf_*; MEM_ARB_PERF_EN enables wait counters).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          if_req,
  input  logic [ADDR_W-1:0]             if_addr,
  output logic                          if_gnt,
  output logic                          if_rvalid,
  output logic [DATA_W-1:0]             if_rdata,
  input  logic                          d_req,
  input  logic                          d_we,
  input  logic [ADDR_W-1:0]             d_addr,
  input  logic [DATA_W-1:0]             d_wdata,
  input  logic [be_width(DATA_W)-1:0]   d_be,
  output logic                          d_gnt,
  output logic                          d_rvalid,
  output logic [DATA_W-1:0]             d_rdata,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic [be_width(DATA_W)-1:0]   mem_be,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          stall_f,
  output logic                          stall_m,
  output logic [31:0]                   perf_if_wait,
  output logic [31:0]                   perf_d_wait
);
  localparam int BE_W = be_width(DATA_W);
  localparam int SW = $clog2(STARVE_MAX + 1);
  arb_state_t state, state_d;
  arb_owner_t owner_q;
  logic we_q, done, gnt, if_wins, starve_hit;
  logic [SW-1:0] starve;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0] be_q;
  mem_arb_lat_timer #(.MEM_LAT(MEM_LAT)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (gnt),
    .done (done)
  );
  assign starve_hit = starve == SW'(STARVE_MAX);
  // Grant logic is gated by rst_n so every output reads 0 while reset is held.
  always_comb begin
    if_wins   = if_req && (!d_req || starve_hit);
    gnt       = rst_n && (state == IDLE || done) && (if_req || d_req);
    if_gnt    = gnt && if_wins;
    d_gnt     = gnt && !if_wins;
    state_d   = gnt ? BUSY : (done ? IDLE : state);
    mem_en    = gnt;
    mem_we    = d_gnt && d_we;
    mem_addr  = if_gnt ? if_addr : (d_gnt ? d_addr : addr_q);
    mem_wdata = if_gnt ? '0 : (d_gnt ? d_wdata : wdata_q);
    mem_be    = if_gnt ? '1 : (d_gnt ? d_be : be_q);
    if_rvalid = done && owner_q == OWN_IF;
    d_rvalid  = done && owner_q == OWN_D;
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = (d_rvalid && !we_q) ? mem_rdata : '0;
    stall_f   = rst_n && if_req && !if_gnt;
    stall_m   = rst_n && d_req && !d_gnt;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      owner_q <= OWN_IF;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state <= state_d;
      if (gnt) begin
        owner_q <= if_gnt ? OWN_IF : OWN_D;
        we_q    <= mem_we;
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
        be_q    <= mem_be;
      end
    end
  // Counts arbitrations IF loses; saturates so IF keeps priority until granted.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) starve <= '0;
    else if (!if_req || if_gnt) starve <= '0;
    else if (d_gnt && !starve_hit) starve <= starve + 1'b1;
`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_if_wait <= '0;
      perf_d_wait  <= '0;
    end else begin
      if (stall_f && !(&perf_if_wait)) perf_if_wait <= perf_if_wait + 1'b1;
      if (stall_m && !(&perf_d_wait)) perf_d_wait <= perf_d_wait + 1'b1;
    end
`else
  assign perf_if_wait = '0;
  assign perf_d_wait  = '0;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic if_req = 1'b0, if_gnt, if_rvalid;
  logic [31:0] if_addr = '0, if_rdata;
  logic d_req = 1'b0, d_we = 1'b0, d_gnt, d_rvalid;
  logic [31:0] d_addr = '0, d_wdata = '0, d_rdata;
  logic [3:0] d_be = '0, mem_be;
  logic mem_en, mem_we, stall_f, stall_m;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0, perf_if_wait, perf_d_wait;
  int checks = 0, failures = 0;
`ifdef MEM_ARB_PERF_EN
  localparam logic [31:0] PERF_IF_EXP = 32'd3;
`else
  localparam logic [31:0] PERF_IF_EXP = 32'd0;
`endif
  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .stall_f(stall_f), .stall_m(stall_m),
    .perf_if_wait(perf_if_wait), .perf_d_wait(perf_d_wait)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    if_req = 1'b1; d_req = 1'b1; if_addr = 32'h55; d_addr = 32'h66;
    #2;
    checks++; if (if_gnt !== 1'b0) begin failures++; $display("FAIL rst_if_gnt got=%h exp=0", if_gnt); end
    checks++; if (d_gnt !== 1'b0) begin failures++; $display("FAIL rst_d_gnt got=%h exp=0", d_gnt); end
    checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL rst_mem_en got=%h exp=0", mem_en); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_be !== 4'h0) begin failures++; $display("FAIL rst_mem_be got=%h exp=0", mem_be); end
    checks++; if ({stall_f, stall_m} !== 2'b00) begin failures++; $display("FAIL rst_stall got=%b exp=00", {stall_f, stall_m}); end
    checks++; if ({perf_if_wait, perf_d_wait} !== 64'h0) begin failures++; $display("FAIL rst_perf got=%h exp=0", {perf_if_wait, perf_d_wait}); end
    tick;
    rst_n = 1'b1; if_req = 1'b0; d_req = 1'b0;
    #1;
    checks++; if ({mem_en, if_rvalid, d_rvalid} !== 3'b000) begin failures++; $display("FAIL rst_idle got=%b exp=000", {mem_en, if_rvalid, d_rvalid}); end
  endtask
  task automatic test_if_read;
    tick;
    if_req = 1'b1; if_addr = 32'h100;
    #1;
    checks++; if ({if_gnt, d_gnt, mem_en, mem_we} !== 4'b1010) begin failures++; $display("FAIL if_grant got=%b exp=1010", {if_gnt, d_gnt, mem_en, mem_we}); end
    checks++; if (mem_addr !== 32'h100) begin failures++; $display("FAIL if_mem_addr got=%h exp=100", mem_addr); end
    checks++; if (mem_be !== 4'hF) begin failures++; $display("FAIL if_mem_be got=%h exp=f", mem_be); end
    tick;
    if_req = 1'b0;
    #1;
    checks++; if ({mem_en, if_rvalid} !== 2'b00) begin failures++; $display("FAIL if_c1 got=%b exp=00", {mem_en, if_rvalid}); end
    checks++; if (mem_addr !== 32'h100) begin failures++; $display("FAIL if_addr_hold got=%h exp=100", mem_addr); end
    tick;
    mem_rdata = 32'hCAFE0001;
    #1;
    checks++; if (if_rvalid !== 1'b1) begin failures++; $display("FAIL if_rvalid got=%h exp=1", if_rvalid); end
    checks++; if (if_rdata !== 32'hCAFE0001) begin failures++; $display("FAIL if_rdata got=%h exp=cafe0001", if_rdata); end
    checks++; if ({d_rvalid, d_rdata} !== 33'h0) begin failures++; $display("FAIL if_d_quiet got=%h exp=0", {d_rvalid, d_rdata}); end
    tick;
    #1;
    checks++; if ({if_rvalid, if_rdata} !== 33'h0) begin failures++; $display("FAIL if_after got=%h exp=0", {if_rvalid, if_rdata}); end
  endtask
  task automatic test_simultaneous;
    tick;
    if_req = 1'b1; if_addr = 32'h104; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
    #1;
    checks++; if ({d_gnt, if_gnt, stall_f, stall_m} !== 4'b1010) begin failures++; $display("FAIL sim_c0 got=%b exp=1010", {d_gnt, if_gnt, stall_f, stall_m}); end
    checks++; if (mem_addr !== 32'h2000) begin failures++; $display("FAIL sim_addr got=%h exp=2000", mem_addr); end
    tick;
    d_req = 1'b0;
    #1;
    checks++; if ({if_gnt, stall_f} !== 2'b01) begin failures++; $display("FAIL sim_c1 got=%b exp=01", {if_gnt, stall_f}); end
    tick;
    mem_rdata = 32'h12345678;
    #1;
    checks++; if ({d_rvalid, if_gnt, stall_f} !== 3'b110) begin failures++; $display("FAIL sim_c2 got=%b exp=110", {d_rvalid, if_gnt, stall_f}); end
    checks++; if (d_rdata !== 32'h12345678) begin failures++; $display("FAIL sim_d_rdata got=%h exp=12345678", d_rdata); end
    checks++; if ({mem_addr, if_rdata} !== {32'h104, 32'h0}) begin failures++; $display("FAIL sim_c2_addr got=%h exp=104/0", {mem_addr, if_rdata}); end
    tick;
    if_req = 1'b0;
    tick;
    mem_rdata = 32'hA5A5A5A5;
    #1;
    checks++; if ({if_rvalid, if_rdata} !== {1'b1, 32'hA5A5A5A5}) begin failures++; $display("FAIL sim_if_resp got=%h exp=1a5a5a5a5", {if_rvalid, if_rdata}); end
    checks++; if ({d_rvalid, d_rdata} !== 33'h0) begin failures++; $display("FAIL sim_d_quiet got=%h exp=0", {d_rvalid, d_rdata}); end
    tick;
  endtask
  task automatic test_store;
    tick;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
    #1;
    checks++; if ({d_gnt, mem_en, mem_we} !== 3'b111) begin failures++; $display("FAIL st_grant got=%b exp=111", {d_gnt, mem_en, mem_we}); end
    checks++; if ({mem_addr, mem_wdata, mem_be} !== {32'h40, 32'hDEADBEEF, 4'b0011}) begin failures++; $display("FAIL st_bus got=%h exp=40/deadbeef/3", {mem_addr, mem_wdata, mem_be}); end
    tick;
    d_req = 1'b0; d_we = 1'b0;
    #1;
    checks++; if ({mem_we, mem_wdata} !== {1'b0, 32'hDEADBEEF}) begin failures++; $display("FAIL st_hold got=%h exp=0deadbeef", {mem_we, mem_wdata}); end
    tick;
    mem_rdata = 32'hFFFFFFFF;
    #1;
    checks++; if ({d_rvalid, d_rdata} !== {1'b1, 32'h0}) begin failures++; $display("FAIL st_resp got=%h exp=100000000", {d_rvalid, d_rdata}); end
    tick;
  endtask
  task automatic test_starve;
    int n_d = 0, cyc = 0;
    tick;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_be = 4'hF; if_req = 1'b1; if_addr = 32'h200;
    #1;
    while (!if_gnt && cyc < 40) begin
      if (d_gnt) n_d++;
      tick;
      #1;
      cyc++;
    end
    checks++; if (if_gnt !== 1'b1) begin failures++; $display("FAIL starve_timeout got=%h exp=1", if_gnt); end
    checks++; if (n_d != 4) begin failures++; $display("FAIL starve_losses got=%0d exp=4", n_d); end
    checks++; if (cyc != 8) begin failures++; $display("FAIL starve_cycle got=%0d exp=8", cyc); end
    checks++; if (mem_addr !== 32'h200) begin failures++; $display("FAIL starve_addr got=%h exp=200", mem_addr); end
    tick;
    if_addr = 32'h204;
    #1;
    checks++; if (stall_f !== 1'b1) begin failures++; $display("FAIL starve_c9 got=%h exp=1", stall_f); end
    tick;
    #1;
    checks++; if ({d_gnt, if_gnt, if_rvalid} !== 3'b101) begin failures++; $display("FAIL starve_clear got=%b exp=101", {d_gnt, if_gnt, if_rvalid}); end
    tick;
    d_req = 1'b0; d_we = 1'b0;
    tick;
    #1;
    checks++; if ({if_gnt, d_rvalid, mem_addr} !== {2'b11, 32'h204}) begin failures++; $display("FAIL starve_c12 got=%h exp=3/204", {if_gnt, d_rvalid, mem_addr}); end
    tick;
    if_req = 1'b0;
    tick;
    tick;
  endtask
  task automatic test_reset_mid;
    tick;
    if_req = 1'b1; if_addr = 32'h300;
    #1;
    checks++; if (if_gnt !== 1'b1) begin failures++; $display("FAIL rm_grant got=%h exp=1", if_gnt); end
    tick;
    if_req = 1'b0; d_req = 1'b1; d_addr = 32'h90; rst_n = 1'b0;
    #1;
    checks++; if ({mem_en, if_gnt, d_gnt, if_rvalid, d_rvalid, stall_f, stall_m} !== 7'b0) begin failures++; $display("FAIL rm_outs got=%b exp=0000000", {mem_en, if_gnt, d_gnt, if_rvalid, d_rvalid, stall_f, stall_m}); end
    checks++; if ({mem_addr, mem_be, mem_wdata} !== 68'h0) begin failures++; $display("FAIL rm_bus got=%h exp=0", {mem_addr, mem_be, mem_wdata}); end
    tick;
    rst_n = 1'b1; d_req = 1'b0;
    #1;
    checks++; if ({if_rvalid, d_rvalid} !== 2'b00) begin failures++; $display("FAIL rm_no_rvalid2 got=%b exp=00", {if_rvalid, d_rvalid}); end
    tick;
    #1;
    checks++; if ({if_rvalid, d_rvalid} !== 2'b00) begin failures++; $display("FAIL rm_no_rvalid3 got=%b exp=00", {if_rvalid, d_rvalid}); end
    if_req = 1'b1; if_addr = 32'h304;
    #1;
    checks++; if ({if_gnt, mem_addr} !== {1'b1, 32'h304}) begin failures++; $display("FAIL rm_regrant got=%h exp=1/304", {if_gnt, mem_addr}); end
    tick;
    if_req = 1'b0;
    tick;
    mem_rdata = 32'h0BADF00D;
    #1;
    checks++; if ({if_rvalid, if_rdata} !== {1'b1, 32'h0BADF00D}) begin failures++; $display("FAIL rm_resp got=%h exp=10badf00d", {if_rvalid, if_rdata}); end
    tick;
  endtask
  task automatic test_perf;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2004;
    #1;
    checks++; if ({d_gnt, stall_m} !== 2'b10) begin failures++; $display("FAIL perf_c0 got=%b exp=10", {d_gnt, stall_m}); end
    tick;
    d_req = 1'b0; if_req = 1'b1; if_addr = 32'h400;
    tick;
    d_req = 1'b1; d_addr = 32'h2008;
    #1;
    checks++; if ({d_gnt, if_gnt, stall_f} !== 3'b101) begin failures++; $display("FAIL perf_c2 got=%b exp=101", {d_gnt, if_gnt, stall_f}); end
    tick;
    d_req = 1'b0;
    tick;
    #1;
    checks++; if (if_gnt !== 1'b1) begin failures++; $display("FAIL perf_if_gnt got=%h exp=1", if_gnt); end
    checks++; if (perf_if_wait !== PERF_IF_EXP) begin failures++; $display("FAIL perf_if_wait got=%0d exp=%0d", perf_if_wait, PERF_IF_EXP); end
    checks++; if (perf_d_wait !== 32'd0) begin failures++; $display("FAIL perf_d_wait got=%0d exp=0", perf_d_wait); end
    if_req = 1'b0;
    tick;
    tick;
  endtask
  initial begin
    test_reset;
    test_if_read;
    test_simultaneous;
    test_store;
    test_starve;
    test_reset_mid;
    test_perf;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
